sram_responder: RTL
===================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of ACCESS-state cycles per transfer; legal range 1..15.
REQ-002 Clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 mem_req  input  1  transfer request from the datapath control; sampled only in IDLE.
REQ-005 mem_we  input  1  1 = write, 0 = read; captured with mem_req.
REQ-006 ADDR  input  20  word address from MAR; captured with mem_req.
REQ-007 wdata  input  16  write data from MDR; captured with mem_req when mem_we=1.
REQ-008 rdata  output  16  read data returned to the datapath.
REQ-009 mem_resp  output  1  one-cycle completion strobe.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 SRAM_ADDR  output  20  address to the SRAM.
REQ-012 SRAM_DQ  inout  16  bidirectional SRAM data bus.
REQ-013 CE_N, OE_N, WE_N, UB_N, LB_N  output  1 each  active-low SRAM strobes.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, ACCESS and DONE.
REQ-015 IDLE with mem_req=1 at an edge SHALL capture ADDR, mem_we and wdata into internal registers and go to SETUP.
REQ-016 IDLE with mem_req=0 SHALL remain in IDLE.
REQ-017 SETUP SHALL last exactly one cycle, clear the wait counter, then go to ACCESS.
REQ-018 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter, then go to DONE.
REQ-019 DONE SHALL last exactly one cycle with mem_resp=1, then go unconditionally to IDLE.
REQ-020 Latency SHALL be fixed: mem_resp is high in cycle WAIT_CYCLES+2 after the accepting edge (cycle 4 for default).
REQ-021 mem_req, ADDR, wdata and mem_we changes outside IDLE SHALL be ignored; the captured values hold for the whole transfer.
REQ-022 Minimum request-to-request spacing SHALL be WAIT_CYCLES+3 cycles; a request held high through DONE is accepted in the following IDLE cycle.
REQ-023 SRAM_ADDR SHALL drive the captured address from SETUP through DONE and 0 in IDLE.
REQ-024 CE_N, UB_N and LB_N SHALL be low in SETUP, ACCESS and DONE and high in IDLE.
REQ-025 Read: OE_N SHALL be low in SETUP and ACCESS; WE_N stays high; SRAM_DQ stays high-Z.
REQ-026 Read: rdata SHALL load SRAM_DQ at the edge ending the last ACCESS cycle and hold until the next read completes.
REQ-027 Write: SRAM_DQ SHALL drive the captured wdata in SETUP, ACCESS and DONE, and be high-Z otherwise.
REQ-028 Write: WE_N SHALL be low only in ACCESS, giving one cycle of data setup and hold; OE_N stays high.
REQ-029 OE_N and WE_N SHALL never be low in the same cycle.
REQ-030 Write transfers SHALL leave rdata unchanged.
REQ-031 All SRAM strobes SHALL come from registers or the registered state only, so they are glitch-free.

Reset
REQ-032 Reset=1 SHALL immediately, without waiting for a Clk edge, force: state IDLE, counter 0, rdata 0x0000, mem_resp 0, busy 0, SRAM_ADDR 0, all strobes high and SRAM_DQ high-Z.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no mem_resp, and SHALL not complete any WE_N-low pulse after assertion.
REQ-034 After Reset deasserts, the first edge with mem_req=1 SHALL be accepted normally.

Verification
REQ-035 Read, WAIT_CYCLES=2, ADDR=0x00123, SRAM model returns 0xBEEF -> OE_N low for cycles 1-3, mem_resp high in cycle 4, rdata=0xBEEF from cycle 4 onward.
REQ-036 Write ADDR=0x00040, wdata=0x1234 -> SRAM_DQ=0x1234 in cycles 1-4, WE_N low only in cycles 2-3, model location 0x00040 reads back 0x1234.
REQ-037 mem_req held high with ADDR changed to 0x00099 during ACCESS -> SRAM_ADDR stays at the first address; second transfer starts in the IDLE cycle after DONE.
REQ-038 Reset pulsed asynchronously during ACCESS of a write -> strobes high and DQ high-Z before the next edge, no mem_resp, busy=0.
REQ-039 WAIT_CYCLES=1 and WAIT_CYCLES=15 builds -> mem_resp in cycle 3 and cycle 17 respectively.
REQ-040 Every test -> assertion that OE_N and WE_N are never both low, and SRAM_DQ is never driven while OE_N is low.

Source files
------------

// File: rtl/sram_responder.sv
// Fixed-latency asynchronous SRAM transfer engine.
// A request accepted in IDLE is captured and walked through SETUP, WAIT_CYCLES
// ACCESS cycles and a one-cycle DONE strobe. Every SRAM strobe, the address bus,
// the DQ output enable and the handshake outputs come straight from flops.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      asynchronous active-high reset
//   mem_req    transfer request, sampled only in IDLE
//   mem_we     1 = write, 0 = read (captured with mem_req)
//   ADDR       20-bit word address (captured with mem_req)
//   wdata      16-bit write data (captured with mem_req on writes)
//   rdata      16-bit read data, updated when a read completes
//   mem_resp   one-cycle completion strobe (DONE)
//   busy       high in every state except IDLE
//   SRAM_ADDR  SRAM address, 0 while idle
//   SRAM_DQ    bidirectional SRAM data bus
//   CE_N, OE_N, WE_N, UB_N, LB_N  active-low SRAM strobes
module sram_responder #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [19:0] ADDR,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        mem_resp,
    output logic        busy,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N,
    output logic        UB_N,
    output logic        LB_N
);

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Output flops, loaded from the next-state decode so they align with state_q.
    logic                resp_q, resp_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                dq_oe_q, dq_oe_d;

    // Next-state, capture and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    addr_d  = ADDR;
                    we_d    = mem_we;
                    wdata_d = mem_we ? wdata : wdata_q;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    // Sample the bus at the edge that closes the last ACCESS cycle.
                    if (!we_q) begin
                        rdata_d = SRAM_DQ;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        resp_d      = (state_d == ST_DONE);
        ce_n_d      = !busy_d;
        // Read enable spans SETUP+ACCESS; write enable only ACCESS, so the data
        // driven from SETUP through DONE gives a cycle of setup and hold.
        oe_n_d      = !(((state_d == ST_SETUP) || (state_d == ST_ACCESS)) && !we_d);
        we_n_d      = !((state_d == ST_ACCESS) && we_d);
        dq_oe_d     = busy_d && we_d;
        sram_addr_d = busy_d ? addr_d : '0;
    end

    // State and datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= 1'b0;
            busy_q      <= 1'b0;
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            busy_q      <= busy_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign SRAM_DQ   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign rdata     = rdata_q;
    assign mem_resp  = resp_q;
    assign busy      = busy_q;
    assign SRAM_ADDR = sram_addr_q;
    assign CE_N      = ce_n_q;
    assign UB_N      = ce_n_q;
    assign LB_N      = ce_n_q;
    assign OE_N      = oe_n_q;
    assign WE_N      = we_n_q;

endmodule
